// File: rtl/tpm_buf_byte_reader.sv
// tpm_buf_byte_reader: reads a byte range out of the shared 32-bit buffer RAM
// and streams it, lowest address first, to the host-side TPM data FIFO.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             transfer request (sampled only while idle)
//   start_addr        first byte address (ADDR_W+2 bits)
//   length            number of bytes, 0 allowed
//   abort             cancel the current transfer (next edge returns to idle)
//   busy, done        transfer active / one-cycle completion pulse
//   ram_req, ram_gnt  request/grant for the arbitrated RAM read port
//   ram_a, ram_rd_en  RAM word address and read enable
//   ram_rd            registered RAM read data (one cycle after ram_rd_en)
//   out_data/valid/ready/last  byte stream towards the FIFO
module tpm_buf_byte_reader #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W+1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_rd_en,
    input  logic [31:0]       ram_rd,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int BA_W = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [BA_W-1:0]   addr_q;
    logic [BA_W-1:0]   addr_d;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  rem_d;
    logic [31:0]       word_q;
    logic [31:0]       word_d;

    logic [BA_W-1:0]   addr_inc;
    logic              last_byte;
    logic [4:0]        lane_sel;

    // Byte address wraps naturally at the top of the buffer.
    assign addr_inc  = addr_q + BA_W'(1);
    assign last_byte = (rem_q == LEN_W'(1));
    assign lane_sel  = {addr_q[1:0], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        word_d    = word_q;
        busy      = 1'b0;
        done      = 1'b0;
        ram_req   = 1'b0;
        ram_a     = '0;
        ram_rd_en = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    addr_d = start_addr;
                    rem_d  = length;
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                busy      = 1'b1;
                ram_req   = 1'b1;
                ram_a     = addr_q[BA_W-1:2];
                ram_rd_en = ram_gnt;
                if (ram_gnt) begin
                    state_d = S_WAIT;
                end
            end

            // The RAM output is only trusted in this cycle; the other
            // client may reuse the read port afterwards.
            S_WAIT: begin
                busy    = 1'b1;
                word_d  = ram_rd;
                state_d = S_STREAM;
            end

            S_STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = word_q[lane_sel +: 8];
                out_last  = last_byte;
                if (out_ready) begin
                    addr_d = addr_inc;
                    rem_d  = rem_q - LEN_W'(1);
                    if (last_byte) begin
                        state_d = S_DONE;
                    end else if (addr_inc[1:0] == 2'b00) begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel wins over every other transition; a byte handshaken in
        // the same cycle still counts as delivered.
        if (abort) begin
            state_d = S_IDLE;
        end
    end

endmodule

// File: tb/tb_tpm_buf_byte_reader.sv
// tb_tpm_buf_byte_reader: scoreboard bench for tpm_buf_byte_reader.
// Expected bytes and RAM word reads are derived from a byte-array view of the RAM.
module tb_tpm_buf_byte_reader;

    localparam int ADDR_W = 9;
    localparam int LEN_W  = 12;
    localparam int NB     = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start;
    logic [10:0] start_addr;
    logic [11:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic        ram_req;
    logic        ram_gnt;
    logic [8:0]  ram_a;
    logic        ram_rd_en;
    logic [31:0] ram_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    tpm_buf_byte_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .ram_req    (ram_req),
        .ram_gnt    (ram_gnt),
        .ram_a      (ram_a),
        .ram_rd_en  (ram_rd_en),
        .ram_rd     (ram_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [512];

    // Registered read port; when not enabled the port shows unrelated data
    // (the other client's reads).
    always @(posedge clk) begin
        ram_rd <= ram_rd_en ? mem[ram_a] : $urandom;
    end

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_b_t;

    exp_b_t exp_q[$];
    int     exp_w[$];
    int     n_tests = 0;
    int     n_fail = 0;
    int     zl_issued = 0;
    int     zl_seen = 0;
    int     gnt_pct = 100;
    int     rdy_pct = 100;
    bit     manual = 1'b1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!manual) begin
            ram_gnt   = ($urandom_range(99) < gnt_pct);
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    endtask

    // Reference: byte k of the transfer lives at (addr+k) mod NB; a word is
    // fetched for the first byte and again at each 4-byte boundary.
    task automatic push_exp(input int addr, input int len);
        int a;
        int w;
        exp_b_t e;
        for (int i = 0; i < len; i++) begin
            a = (addr + i) % NB;
            w = a / 4;
            if (i == 0 || (a % 4) == 0) exp_w.push_back(w);
            e.d = 8'((mem[w] >> (8 * (a % 4))) & 32'hff);
            e.l = (i == len - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input int addr, input int len);
        start      = 1'b1;
        start_addr = 11'(addr);
        length     = 12'(len);
        push_exp(addr, len);
        tick();
        start      = 1'b0;
        start_addr = 11'($urandom);
        length     = 12'($urandom);
        if (len == 0) zl_issued++;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while ((busy || done) && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_timeout"}, {62'd0, busy, done}, 64'd0);
        chk({name, "_bytes_left"}, exp_q.size(), 0);
        chk({name, "_reads_left"}, exp_w.size(), 0);
    endtask

    task automatic monitor();
        bit         done_due;
        bit         stall;
        bit         exp_done;
        logic [7:0] pd;
        logic       pl;
        exp_b_t     e;
        int         w;
        done_due = 1'b0;
        stall = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_due = 1'b0;
                stall = 1'b0;
                continue;
            end
            exp_done = done_due;
            if (zl_issued > zl_seen) begin
                exp_done = 1'b1;
                zl_seen++;
            end
            if (done || exp_done) chk("done_pulse", done, exp_done);
            done_due = 1'b0;
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {out_last, out_data}, {pl, pd});
            end
            stall = 1'b0;
            if (ram_req && !ram_rd_en && exp_w.size() == 0)
                chk("stray_req", ram_req, 0);
            if (ram_rd_en) begin
                chk("rd_en_qual", {ram_req, ram_gnt}, 2'b11);
                if (exp_w.size() == 0) begin
                    chk("extra_read", ram_rd_en, 0);
                end else begin
                    w = exp_w.pop_front();
                    chk("ram_a", ram_a, w);
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", out_valid, 0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk("byte", {out_last, out_data}, {e.l, e.d});
                    if (e.l && !abort) done_due = 1'b1;
                end else begin
                    stall = !abort;
                    pd = out_data;
                    pl = out_last;
                end
            end
        end
    endtask

    initial begin
        int c;
        int n;
        int k;
        logic [3:0] pat;

        start = 1'b0;
        abort = 1'b0;
        ram_gnt = 1'b0;
        out_ready = 1'b0;
        start_addr = '0;
        length = '0;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;

        fork
            monitor();
        join_none

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        chk("reset_outputs",
            {busy, done, ram_req, ram_rd_en, ram_a,
             out_valid, out_last, out_data}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Aligned read with latency check
        manual = 1'b0;
        gnt_pct = 100;
        rdy_pct = 100;
        mem[0] = 32'h4433_2211;
        tick();
        issue(0, 4);
        c = 1;
        while (!out_valid && c < 10) begin
            tick();
            c++;
        end
        chk("first_valid_cycle", c, 3);
        wait_idle("aligned", 50);

        // Unaligned, crossing a word boundary
        mem[1] = 32'h8877_6655;
        mem[2] = 32'hCCBB_AA99;
        issue(6, 4);
        wait_idle("unaligned", 50);

        // Top-of-buffer wrap
        mem[511] = 32'hDDCC_BBAA;
        issue(11'h7FE, 4);
        wait_idle("wrap", 50);

        // Grant stall, ready pattern, start while busy
        manual = 1'b1;
        ram_gnt = 1'b0;
        out_ready = 1'b0;
        issue(11'h021, 8);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", {ram_req, ram_rd_en, out_valid}, 3'b100);
            tick();
        end
        ram_gnt = 1'b1;
        pat = 4'b1001;
        k = 0;
        while ((busy || done) && k < 300) begin
            out_ready = pat[k % 4];
            start = (k == 3 || k == 7);
            start_addr = 11'h000;
            length = 12'd1;
            tick();
            k++;
        end
        start = 1'b0;
        chk("stall_timeout", {busy, done}, 2'b00);
        chk("stall_bytes_left", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ignored_start", {busy, done}, 2'b00);
        end

        // Zero length
        manual = 1'b0;
        gnt_pct = 100;
        rdy_pct = 100;
        tick();
        issue(11'h155, 0);
        wait_idle("zero_len", 10);

        // Abort after two bytes, then a fresh 1-byte transfer
        issue(11'h040, 8);
        n = 0;
        c = 0;
        while (c < 50) begin
            if (out_valid && out_ready) begin
                n++;
                if (n == 2) break;
            end
            tick();
            c++;
        end
        chk("abort_reach", n, 2);
        abort = 1'b1;
        tick();
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        exp_w.delete();
        abort = 1'b0;
        issue(11'h047, 1);
        wait_idle("after_abort", 50);

        // Asynchronous reset mid-transfer
        issue(11'h200, 12);
        for (int i = 0; i < 5; i++) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset",
            {busy, done, ram_req, ram_rd_en, ram_a,
             out_valid, out_last, out_data}, 0);
        exp_q.delete();
        exp_w.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {busy, done}, 2'b00);
        issue(11'h203, 5);
        wait_idle("post_reset", 100);

        // Length longer than the buffer
        issue(11'h7F0, 2060);
        wait_idle("long", 10000);

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 512; i++) mem[i] = $urandom;
            gnt_pct = $urandom_range(20, 100);
            rdy_pct = $urandom_range(20, 100);
            tick();
            if ($urandom_range(5) == 0) issue($urandom_range(NB - 1), 0);
            else issue($urandom_range(NB - 1), $urandom_range(1, 24));
            wait_idle("random", 5000);
        end

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
